// File: rtl/fft_pkg.sv
// Shared FFT-path definitions: default stream widths and peak-detector state encoding.
package fft_pkg;

  localparam int unsigned MAG_W  = 32;
  localparam int unsigned N_BINS = 64;
  localparam int unsigned IDX_W  = 6;

  typedef enum logic {
    ST_SCAN = 1'b0,
    ST_HOLD = 1'b1
  } pd_state_e;

endpackage

// File: rtl/peak_compare_reg.sv
// Running-maximum register pair: holds the largest magnitude seen so far and its bin index.
module peak_compare_reg
  import fft_pkg::*;
#(
  parameter int unsigned MAG_W = fft_pkg::MAG_W,
  parameter int unsigned IDX_W = fft_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [MAG_W-1:0] cand_mag,
  input  logic [IDX_W-1:0] cand_idx,
  output logic [MAG_W-1:0] nxt_max_c,
  output logic [IDX_W-1:0] nxt_idx_c
);

  logic [MAG_W-1:0] max_q, max_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Strictly-greater update so ties keep the earlier (lower) index.
  always_comb begin
    nxt_max_c = max_q;
    nxt_idx_c = idx_q;
    if (en && (cand_mag > max_q)) begin
      nxt_max_c = cand_mag;
      nxt_idx_c = cand_idx;
    end
    max_d = clr ? '0 : nxt_max_c;
    idx_d = clr ? '0 : nxt_idx_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
      idx_q <= '0;
    end else begin
      max_q <= max_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/fft_peak_detector.sv
// Scans one frame of FFT magnitudes and reports the largest bin on a valid/ready result port.
module fft_peak_detector
  import fft_pkg::*;
#(
  parameter int unsigned     MAG_W   = fft_pkg::MAG_W,
  parameter int unsigned     N_BINS  = fft_pkg::N_BINS,
  parameter int unsigned     IDX_W   = fft_pkg::IDX_W,
  parameter bit              SKIP_DC = 1'b1,
  parameter logic [MAG_W-1:0] THRESH = MAG_W'(32'h0000_0100)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mag_valid,
  output logic             mag_ready,
  input  logic [MAG_W-1:0] mag_data,
  input  logic             mag_last,
  output logic             peak_valid,
  input  logic             peak_ready,
  output logic [IDX_W-1:0] peak_bin,
  output logic [MAG_W-1:0] peak_mag,
  output logic             peak_found,
  output logic             frame_err
);

  pd_state_e        state_q, state_d;
  logic [IDX_W-1:0] bin_cnt_q, bin_cnt_d;
  logic             mag_ready_q, mag_ready_d;
  logic             peak_valid_q, peak_valid_d;
  logic [IDX_W-1:0] peak_bin_q, peak_bin_d;
  logic [MAG_W-1:0] peak_mag_q, peak_mag_d;
  logic             peak_found_q, peak_found_d;
  logic             frame_err_q, frame_err_d;

  logic             accept_c;
  logic             last_bin_c;
  logic             frame_end_c;
  logic             cmp_en_c;
  logic [MAG_W-1:0] run_max_nxt_c;
  logic [IDX_W-1:0] run_idx_nxt_c;

  assign accept_c    = mag_valid & mag_ready_q;
  assign last_bin_c  = (bin_cnt_q == IDX_W'(N_BINS - 1));
  assign frame_end_c = accept_c & (mag_last | last_bin_c);
  assign cmp_en_c    = accept_c & ((bin_cnt_q != '0) | (SKIP_DC == 1'b0));

  // Final beat is folded into the comparison and the running max cleared on the same edge.
  peak_compare_reg #(
    .MAG_W (MAG_W),
    .IDX_W (IDX_W)
  ) u_cmp (
    .clk       (clk),
    .rst_n     (rst),
    .clr       (frame_end_c),
    .en        (cmp_en_c),
    .cand_mag  (mag_data),
    .cand_idx  (bin_cnt_q),
    .nxt_max_c (run_max_nxt_c),
    .nxt_idx_c (run_idx_nxt_c)
  );

  always_comb begin
    state_d      = state_q;
    bin_cnt_d    = bin_cnt_q;
    peak_valid_d = peak_valid_q;
    peak_bin_d   = peak_bin_q;
    peak_mag_d   = peak_mag_q;
    peak_found_d = peak_found_q;
    frame_err_d  = frame_err_q;
    unique case (state_q)
      ST_SCAN: begin
        if (accept_c) begin
          bin_cnt_d = bin_cnt_q + IDX_W'(1);
        end
        if (frame_end_c) begin
          bin_cnt_d    = '0;
          peak_mag_d   = run_max_nxt_c;
          peak_bin_d   = run_idx_nxt_c;
          peak_found_d = (run_max_nxt_c >= THRESH);
          frame_err_d  = mag_last ^ last_bin_c;
          peak_valid_d = 1'b1;
          state_d      = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (peak_valid_q && peak_ready) begin
          peak_valid_d = 1'b0;
          state_d      = ST_SCAN;
        end
      end
    endcase
    // Ready follows the next state only, so peak_ready never reaches mag_ready combinationally.
    mag_ready_d = (state_d == ST_SCAN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_SCAN;
      bin_cnt_q    <= '0;
      mag_ready_q  <= 1'b0;
      peak_valid_q <= 1'b0;
      peak_bin_q   <= '0;
      peak_mag_q   <= '0;
      peak_found_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bin_cnt_q    <= bin_cnt_d;
      mag_ready_q  <= mag_ready_d;
      peak_valid_q <= peak_valid_d;
      peak_bin_q   <= peak_bin_d;
      peak_mag_q   <= peak_mag_d;
      peak_found_q <= peak_found_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign mag_ready  = mag_ready_q;
  assign peak_valid = peak_valid_q;
  assign peak_bin   = peak_bin_q;
  assign peak_mag   = peak_mag_q;
  assign peak_found = peak_found_q;
  assign frame_err  = frame_err_q;

endmodule

// File: doc/fft_peak_detector.md
Name: fft_peak_detector

Overview:
- Downstream consumer of the FFT/DFT core's 32-bit Magnitude stream.
- Scans one frame of N_BINS magnitudes and reports the bin index and value of the largest magnitude.
- Holds each result on a valid/ready port until the display/control logic takes it, back-pressuring the magnitude stream meanwhile.

Parameters:
- MAG_W, 32, magnitude width (matches the core's Magnitude output)
- N_BINS, 64, bins per frame; power of two, >= 4
- IDX_W, 6, bin index width = log2(N_BINS)
- SKIP_DC, 1, 1 = bin 0 is excluded from the peak search
- THRESH, 32'h0000_0100, minimum magnitude counted as a real peak

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- mag_valid  in  1  mag_data is valid this cycle
- mag_ready  out  1  block accepts mag_data this cycle
- mag_data  in  MAG_W  bin magnitude, unsigned, bins in ascending order
- mag_last  in  1  marks the final bin of a frame
- peak_valid  out  1  result available
- peak_ready  in  1  consumer takes result
- peak_bin  out  IDX_W  index of maximum bin
- peak_mag  out  MAG_W  magnitude of maximum bin
- peak_found  out  1  peak_mag >= THRESH
- frame_err  out  1  frame length mismatch on the reported frame

Behaviour:
- Reset (rst=0, async):
  - state=SCAN; bin_cnt=0; running max=0, index=0.
  - peak_valid=0, peak_bin=0, peak_mag=0, peak_found=0, frame_err=0, mag_ready=0.
  - Outputs release on the first clk edge after rst deasserts.
- States: SCAN, HOLD.
- SCAN:
  - mag_ready=1. A beat is accepted when mag_valid & mag_ready.
  - Per accepted beat: if (bin_cnt!=0 || !SKIP_DC) and mag_data > run_max (strictly greater), then run_max<=mag_data and run_idx<=bin_cnt. Ties keep the lower index.
  - bin_cnt increments per accepted beat and wraps at N_BINS.
- End of frame: the frame ends on the accepted beat with mag_last=1, or on the beat where bin_cnt==N_BINS-1, whichever comes first.
  - The comparison includes that final beat.
  - Result registers load on the same edge: peak_mag/peak_bin = final max/index; peak_found = (final max >= THRESH).
  - frame_err=1 if mag_last and bin_cnt==N_BINS-1 did not coincide (early last, or missing last at bin N_BINS-1).
  - Then: peak_valid<=1, state<=HOLD, bin_cnt<=0, run_max<=0, run_idx<=0.
- Latency: peak_valid rises on the clock edge that accepts the final beat, i.e. visible 1 cycle after that beat is presented.
- HOLD:
  - mag_ready=0; peak_* outputs stable.
  - On peak_valid & peak_ready: peak_valid<=0, state<=SCAN, mag_ready=1 next cycle. Minimum one bubble cycle per frame.
- Frame with no qualifying bin (all zero, or SKIP_DC with only bin 0 nonzero): peak_bin=0, peak_mag=0, peak_found=0.
- mag_valid while mag_ready=0: not accepted; the upstream holds the data.
- Reset asserted mid-frame or in HOLD: partial frame and result are discarded; all outputs return to reset values immediately.
- Comparison is unsigned over the full MAG_W; no truncation or saturation.
- mag_ready is a registered function of state only; no combinational path from peak_ready to mag_ready.

Decomposition:
- Shared package fft_pkg:
  - MAG_W, N_BINS and IDX_W defaults, also used by the FFT core.
  - State encoding constants ST_SCAN, ST_HOLD.
- One natural sub-module, peak_compare_reg: the running-max register pair with clear/enable/compare. The top holds the FSM, bin counter and output registers.

Test Plan:
- Ramp frame: mag_data=bin index (0..63), mag_last on bin 63, peak_ready=1 → peak_bin=63, peak_mag=63 (0x3F), peak_found=0, frame_err=0, peak_valid for 1 cycle.
- Single spike: bin 17=0x0001_0000, others 0x10; hold peak_ready=0 for 5 cycles → peak_bin=17, peak_found=1, peak_* stable, mag_ready=0 throughout HOLD.
- Tie and DC: bins 0, 5 and 9 all =0xFFFF_FFFF, others 0, SKIP_DC=1 → peak_bin=5, peak_mag=0xFFFF_FFFF; rerun with SKIP_DC=0 → peak_bin=0.
- Framing: mag_last at bin 40 → result after bin 40, frame_err=1. Then mag_last=0 on bin 63 of a full frame → frame ends at bin 63, frame_err=1. Next well-formed frame → frame_err=0.
- Back-to-back frames with mag_valid held high and random peak_ready stalls → every frame reported once in order, no beat lost or duplicated (scoreboard vs reference max).
- Reset mid-frame at bin 30 → outputs zero immediately. A new full frame after release reports only new data, bin_cnt restarts at 0.
